// File: rtl/func_gen_pkg.sv
// Shared constants for the waveform controller.
// Holds the requested-mode and controller-state encodings and the
// generator sample width. Imported by wave_ctrl and wave_prescaler.
package func_gen_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_OFF    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RESTART = 2'd3
  } state_t;

endpackage

// File: rtl/wave_prescaler.sv
// Programmable step prescaler for the waveform generators.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous reset, active-low
//   run   - count enable (controller in RUN or DRAIN)
//   clear - restart the period from zero and load a fresh div
//   div   - period minus one, sampled only when a period starts
//   tick  - high in the cycle the count equals the loaded period
module wave_prescaler
  import func_gen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] period;

  assign tick = run && (count == period);

  // The period is reloaded only when a new period starts (clear or wrap),
  // so a div change mid-count lands in the following period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= '0;
      period <= '0;
    end else if (clear) begin
      count  <= '0;
      period <= div;
    end else if (run) begin
      if (tick) begin
        count  <= '0;
        period <= div;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wave_ctrl.sv
// Waveform mode controller.
// Accepts mode requests, drains the running waveform until a rising zero
// crossing (or a timeout), restarts the generators and drives a scaled,
// registered output sample.
// Ports:
//   clk, rst           - clock; synchronous active-low reset
//   mode_req/valid     - requested mode (0 sine,1 square,2 tri,3 off) + strobe
//   mode_ready         - request can be accepted this cycle
//   div                - generator step period minus one
//   amp_sel            - arithmetic right-shift amount 0..3
//   sin_in/sq_in/tri_in- signed generator samples
//   gen_en, gen_rst    - generator step strobe and restart pulse
//   wave_out           - registered scaled sample of the active mode
//   mode_cur           - mode driving wave_out
//   busy               - DRAIN or RESTART in progress
module wave_ctrl
  import func_gen_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_req,
  input  logic             mode_valid,
  output logic             mode_ready,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       amp_sel,
  input  logic [7:0]       sin_in,
  input  logic [7:0]       sq_in,
  input  logic [7:0]       tri_in,
  output logic             gen_en,
  output logic             gen_rst,
  output logic [7:0]       wave_out,
  output logic [1:0]       mode_cur,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Compare against TIMEOUT-1 so the exit edge is the one where the counter
  // reaches TIMEOUT: DRAIN then lasts exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic signed [SAMPLE_W-1:0] atten(
    input logic signed [SAMPLE_W-1:0] s,
    input logic [1:0]                 sh
  );
    atten = s >>> sh;
  endfunction

  state_t                      state;
  state_t                      state_next;
  logic [1:0]                  mode_nxt;
  logic [CNT_W-1:0]            drain_cnt;
  logic                        prev_neg;
  logic                        accept;
  logic                        enter_drain;
  logic                        drain_exit;
  logic                        run;
  logic signed [SAMPLE_W-1:0]  sample_p0;

  assign run    = (state == ST_RUN) || (state == ST_DRAIN);
  assign accept = mode_valid && mode_ready;

  wave_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (state == ST_RESTART),
    .div   (div),
    .tick  (gen_en)
  );

  always_comb begin
    unique case (mode_cur)
      MODE_SINE:   sample_p0 = $signed(sin_in);
      MODE_SQUARE: sample_p0 = $signed(sq_in);
      MODE_TRI:    sample_p0 = $signed(tri_in);
      default:     sample_p0 = '0;
    endcase
  end

  // Rising zero crossing between two consecutive step samples, or timeout.
  assign drain_exit = (gen_en && prev_neg && !sample_p0[SAMPLE_W-1]) ||
                      (drain_cnt == DRAIN_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_OFF;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mode_ready  = 1'b0;
    busy        = 1'b0;
    gen_rst     = 1'b0;
    enter_drain = 1'b0;
    unique case (state)
      ST_OFF: begin
        mode_ready = 1'b1;
        if (mode_valid && (mode_req != MODE_OFF)) state_next = ST_RESTART;
      end
      ST_RUN: begin
        mode_ready = 1'b1;
        if (mode_valid && (mode_req != mode_cur)) begin
          state_next  = ST_DRAIN;
          enter_drain = 1'b1;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_exit) state_next = (mode_nxt == MODE_OFF) ? ST_OFF : ST_RESTART;
      end
      ST_RESTART: begin
        busy       = 1'b1;
        gen_rst    = 1'b1;
        state_next = ST_RUN;
      end
    endcase
  end

  // ---- stage p0 -> output register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_cur  <= MODE_OFF;
      mode_nxt  <= MODE_OFF;
      drain_cnt <= '0;
      prev_neg  <= 1'b0;
      wave_out  <= '0;
    end else begin
      if (accept) mode_nxt <= mode_req;
      if (state == ST_RESTART)
        mode_cur <= mode_nxt;
      else if ((state == ST_DRAIN) && (state_next == ST_OFF))
        mode_cur <= MODE_OFF;
      if (enter_drain) begin
        drain_cnt <= '0;
        prev_neg  <= 1'b0;
      end else begin
        if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
        if (gen_en) prev_neg <= sample_p0[SAMPLE_W-1];
      end
      // Looking at the next state keeps wave_out at zero for every OFF cycle.
      wave_out <= (state_next == ST_OFF) ? '0 : atten(sample_p0, amp_sel);
    end
  end

endmodule
